// File: rtl/nthu_ssd_pkg.sv
// ---------------------------------------------------------------------------
// nthu_ssd_pkg
// Constants shared by the scrolling controller and the seven-segment letter
// decoder: letter indices for the message n-t-h-u-e, message length, digit
// count, and a small mod-5 add helper.
// ---------------------------------------------------------------------------
package nthu_ssd_pkg;

    typedef logic [2:0] ltr_idx_t;

    localparam ltr_idx_t LTR_N = 3'd0;
    localparam ltr_idx_t LTR_T = 3'd1;
    localparam ltr_idx_t LTR_H = 3'd2;
    localparam ltr_idx_t LTR_U = 3'd3;
    localparam ltr_idx_t LTR_E = 3'd4;

    localparam int NUM_LTR    = 5;
    localparam int NUM_DIGITS = 4;

    // Operands are at most 4 and 3, so the 3-bit sum never overflows and a
    // single conditional subtract brings it back into 0..4.
    function automatic ltr_idx_t add_mod5(input ltr_idx_t a, input ltr_idx_t b);
        ltr_idx_t s;
        s = a + b;
        if (s >= 3'(NUM_LTR))
            s = s - 3'(NUM_LTR);
        return s;
    endfunction

endpackage

// File: rtl/nthu_scroll_ctrl_tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// Free-running modulo-DIV counter that advances only while cnt_en is high
// and holds otherwise. tick is high for the one enabled cycle in which the
// count sits at DIV-1; that same edge wraps the count to 0.
//
// Ports:
//   clk     in  1  system clock
//   rst     in  1  asynchronous active-high reset
//   cnt_en  in  1  count enable
//   tick    out 1  one-cycle pulse at count DIV-1 (qualified by cnt_en)
// ---------------------------------------------------------------------------
module tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic cnt_en,
    output logic tick
);

    localparam int W = $clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] r_cnt;
    logic         w_at_last;

    assign w_at_last = (r_cnt == LAST);
    assign tick      = cnt_en && w_at_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (cnt_en) begin
            if (w_at_last)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/nthu_scroll_ctrl.sv
// ---------------------------------------------------------------------------
// nthu_scroll_ctrl
// Scrolls the five-letter message n-t-h-u-e across a four-digit seven-segment
// display. Keeps the window start position and the currently lit digit,
// and emits the letter index for that digit plus active-low digit enables.
//
// Optional feature macro: NTHU_SCROLL_DIR_EN
//   defined   -> dir port exists; dir=1 scrolls in reverse
//   undefined -> no dir port; scrolling is always forward
//
// Ports:
//   clk      in  1  system clock
//   rst      in  1  asynchronous active-high reset
//   en       in  1  scroll enable (0 freezes the message, scan continues)
//   dir      in  1  scroll direction, 1 = reverse (NTHU_SCROLL_DIR_EN only)
//   i        out 3  letter index for the lit digit (0..4)
//   ssd_ctl  out 4  digit enables, active-low, bit 0 = rightmost digit
// ---------------------------------------------------------------------------
module nthu_scroll_ctrl
    import nthu_ssd_pkg::*;
#(
    parameter int SCROLL_DIV = 100_000_000,
    parameter int SCAN_DIV   = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
`ifdef NTHU_SCROLL_DIR_EN
    input  logic       dir,
`endif
    output logic [2:0] i,
    output logic [3:0] ssd_ctl
);

    ltr_idx_t   r_pos;
    logic [1:0] r_scan;

    logic       w_scan_tick;
    logic       w_scroll_tick;
    logic       w_dir;
    ltr_idx_t   w_pos_next;
    ltr_idx_t   w_offs;

`ifdef NTHU_SCROLL_DIR_EN
    assign w_dir = dir;
`else
    assign w_dir = 1'b0;
`endif

    tick_gen #(.DIV(SCAN_DIV)) u_scan_tick (
        .clk    (clk),
        .rst    (rst),
        .cnt_en (1'b1),
        .tick   (w_scan_tick)
    );

    tick_gen #(.DIV(SCROLL_DIV)) u_scroll_tick (
        .clk    (clk),
        .rst    (rst),
        .cnt_en (en),
        .tick   (w_scroll_tick)
    );

    always_comb begin
        w_pos_next = r_pos;
        if (w_dir)
            w_pos_next = (r_pos == LTR_N) ? LTR_E : r_pos - 3'd1;
        else
            w_pos_next = (r_pos == LTR_E) ? LTR_N : r_pos + 3'd1;
    end

    // Scan and scroll updates are independent, so a coincident tick moves
    // both on the same edge and the outputs switch together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pos  <= LTR_N;
            r_scan <= 2'd0;
        end else begin
            if (w_scan_tick)
                r_scan <= r_scan + 2'd1;
            if (w_scroll_tick)
                r_pos <= w_pos_next;
        end
    end

    // Digit k shows letter (pos + 3 - k) mod 5; outputs depend only on
    // registered state.
    assign w_offs  = 3'(NUM_DIGITS - 1) - {1'b0, r_scan};
    assign i       = add_mod5(r_pos, w_offs);
    assign ssd_ctl = ~(4'b0001 << r_scan);

endmodule

// File: tb/tb_nthu_scroll_ctrl.sv
module tb_nthu_scroll_ctrl;

    localparam int SCROLL_DIV = 8;
    localparam int SCAN_DIV   = 2;

    typedef struct packed {
        logic [3:0] ssd;
        logic [2:0] idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic       dir = 1'b0;
    logic [2:0] i;
    logic [3:0] ssd_ctl;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // reference model state: plain counts since reset release
    int m_cyc  = 0;
    int m_ecnt = 0;
    int m_pos  = 0;

    always #5 clk = ~clk;

    nthu_scroll_ctrl #(
        .SCROLL_DIV (SCROLL_DIV),
        .SCAN_DIV   (SCAN_DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
`ifdef NTHU_SCROLL_DIR_EN
        .dir     (dir),
`endif
        .i       (i),
        .ssd_ctl (ssd_ctl)
    );

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // One rising edge worth of model: position from enabled-cycle count,
    // lit digit from elapsed cycles, letter from the window formula.
    task automatic model_step();
        int scan;
        exp_t e;
        m_cyc++;
        if (en) begin
            m_ecnt++;
            if (m_ecnt % SCROLL_DIV == 0) begin
`ifdef NTHU_SCROLL_DIR_EN
                if (dir) m_pos = (m_pos + 4) % 5;
                else     m_pos = (m_pos + 1) % 5;
`else
                m_pos = (m_pos + 1) % 5;
`endif
            end
        end
        scan  = (m_cyc / SCAN_DIV) % 4;
        e.ssd = 4'(15 - (1 << scan));
        e.idx = 3'((m_pos + 3 - scan) % 5);
        q.push_back(e);
    endtask

    // Called at a falling edge; drives, lets one rising edge pass, returns
    // at the next falling edge.
    task automatic run_cycle(input logic en_v, input logic dir_v);
        en  = en_v;
        dir = dir_v;
        @(posedge clk);
        #1 model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        #1;
        chk("reset_ssd", ssd_ctl, 4'b1110);
        chk("reset_i", i, 3);
        repeat (2) @(negedge clk);
        chk("reset_hold_ssd", ssd_ctl, 4'b1110);
        q.delete();
        m_cyc = 0; m_ecnt = 0; m_pos = 0;
        rst = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ssd_ctl", ssd_ctl, e.ssd);
                chk("i", i, e.idx);
                chk("i_range", (i <= 3'd4), 1);
            end
        end
    end

    initial begin : stim
        bit reached;
        #1 rst = 1'b1;
        @(negedge clk);
        do_reset();

        // scan only, message frozen
        repeat (16) run_cycle(1'b0, 1'b0);

        // forward scroll through a full revolution
        do_reset();
        repeat (5 * SCROLL_DIV) run_cycle(1'b1, 1'b0);
        chk("fwd_pos_wrap", m_pos, 0);

        // freeze mid-count, then resume
        do_reset();
        repeat (5)  run_cycle(1'b1, 1'b0);
        repeat (20) run_cycle(1'b0, 1'b0);
        repeat (4)  run_cycle(1'b1, 1'b0);

`ifdef NTHU_SCROLL_DIR_EN
        // reverse from reset: 0 -> 4 -> 3
        do_reset();
        repeat (2 * SCROLL_DIV) run_cycle(1'b1, 1'b1);
        chk("rev_pos", m_pos, 3);
`endif

        // randomized enable / direction
        do_reset();
        for (int n = 0; n < 400; n++)
            run_cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));

        // async reset in the middle of a cycle once pos reaches 2
        do_reset();
        reached = 0;
        for (int n = 0; n < 100 && !reached; n++) begin
            run_cycle(1'b1, 1'b0);
            if (m_pos == 2) reached = 1;
        end
        chk("reach_pos2", reached, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ssd", ssd_ctl, 4'b1110);
        chk("async_rst_i", i, 3);
        q.delete();
        @(negedge clk);
        m_cyc = 0; m_ecnt = 0; m_pos = 0;
        rst = 1'b0;
        repeat (12) run_cycle(1'b1, 1'b0);

        @(negedge clk);
        #1 chk("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
